dma_rd_burst_ctrl: RTL and testbench



---
 rtl/dma_rd_burst_ctrl_if.sv | 46 ++++
 rtl/dma_rd_burst_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_dma_rd_burst_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_rd_burst_ctrl_if.sv
// ---------------------------------------------------------------------------
// dma_rd_burst_ctrl_if
// Groups the AXI read-address channel and the monitored R-channel strobes
// used by the frame read DMA sequencer.
//
//   arvalid  AR valid            (sequencer -> memory)
//   arready  AR ready            (memory -> sequencer)
//   araddr   burst start address (sequencer -> memory)
//   arlen    beats-1             (sequencer -> memory)
//   rvalid   R valid             (memory -> sequencer, monitor only)
//   rready   R ready             (pixel FIFO side, monitor only)
//   rlast    R last beat         (memory -> sequencer)
//
// Modports: master = the sequencer, slave = the memory / pixel FIFO side.
// ---------------------------------------------------------------------------
interface dma_rd_burst_ctrl_if #(
    parameter int AXI_ADDR_WIDTH = 32
);
    logic                      arvalid;
    logic                      arready;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                arlen;
    logic                      rvalid;
    logic                      rready;
    logic                      rlast;

    modport master (
        output arvalid,
        output araddr,
        output arlen,
        input  arready,
        input  rvalid,
        input  rready,
        input  rlast
    );

    modport slave (
        input  arvalid,
        input  araddr,
        input  arlen,
        output arready,
        output rvalid,
        output rready,
        output rlast
    );
endinterface

// File: rtl/dma_rd_burst_ctrl.sv
// ---------------------------------------------------------------------------
// dma_rd_burst_ctrl
// AXI read-address sequencer (clk_axi domain) that fetches one image frame
// into the pixel pipeline. On a trigger it latches base address, width and
// height, splits every line into INCR bursts that never cross a 4 KB page,
// bounds the number of bursts awaiting rlast, and raises a level done once
// every burst has been issued and terminated.
//
// Ports:
//   clk_axi             AXI clock
//   rst                 synchronous active-high reset
//   dma_trigger_i       level trigger (already synchronized)
//   dma_trigger_done_o  level done, held until the trigger drops
//   mem_addr_i          frame base address, 8-byte aligned
//   image_width_i       pixels per line (4 B/pixel, 8 B/beat)
//   image_height_i      lines per frame
//   axi                 AR channel + R monitor (dma_rd_burst_ctrl_if.master)
//   busy_o              high whenever the sequencer is not idle
//   line_issued_o       1-cycle pulse after the last AR of a line handshakes
// ---------------------------------------------------------------------------
module dma_rd_burst_ctrl #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int MAX_BURST_BEATS = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk_axi,
    input  logic                      rst,
    input  logic                      dma_trigger_i,
    output logic                      dma_trigger_done_o,
    input  logic [AXI_ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [11:0]               image_width_i,
    input  logic [11:0]               image_height_i,
    dma_rd_burst_ctrl_if.master       axi,
    output logic                      busy_o,
    output logic                      line_issued_o
);

    localparam int               CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] OS_MAX    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [12:0]      BURST_MAX = 13'(MAX_BURST_BEATS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                    state_q,       state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q,        addr_d;       // start of the next burst
    logic [11:0]               bpl_q,         bpl_d;        // beats per line
    logic [11:0]               height_q,      height_d;
    logic [11:0]               line_rem_q,    line_rem_d;   // beats left in current line
    logic [11:0]               lines_rem_q,   lines_rem_d;  // lines left, current included
    logic [CNT_W-1:0]          os_cnt_q,      os_cnt_d;     // bursts awaiting rlast
    logic                      arvalid_q,     arvalid_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q,      araddr_d;
    logic [7:0]                arlen_q,       arlen_d;
    logic                      line_issued_q, line_issued_d;

    // Burst length limited by the configured maximum, the beats left in the
    // line and the room left before the next 4 KB page boundary.
    function automatic logic [8:0] calc_len(input logic [11:0] page_off,
                                            input logic [11:0] rem);
        logic [12:0] room;
        logic [12:0] len;
        room = (13'd4096 - {1'b0, page_off}) >> 3;
        len  = BURST_MAX;
        if ({1'b0, rem} < len) begin
            len = {1'b0, rem};
        end
        if (room < len) begin
            len = room;
        end
        return 9'(len);
    endfunction

    logic                      ar_hs;
    logic                      r_dec;
    logic [8:0]                burst_len;
    logic [AXI_ADDR_WIDTH-1:0] addr_nx;
    logic [11:0]               line_rem_after;
    logic                      line_done;
    logic [11:0]               line_rem_nx;
    logic [11:0]               lines_rem_nx;
    logic                      frame_issued;
    logic [8:0]                next_len;

    // Bookkeeping as it will stand after this cycle's AR handshake, so the
    // following burst can be presented without a bubble.
    always_comb begin
        ar_hs          = arvalid_q & axi.arready;
        // An rlast with nothing outstanding is a stray beat and is dropped.
        r_dec          = axi.rvalid & axi.rready & axi.rlast & (os_cnt_q != '0);
        burst_len      = {1'b0, arlen_q} + 9'd1;
        line_rem_after = line_rem_q - {3'b000, burst_len};
        line_done      = ar_hs & (line_rem_after == 12'd0);
        frame_issued   = line_done & (lines_rem_q == 12'd1);

        addr_nx      = addr_q;
        line_rem_nx  = line_rem_q;
        lines_rem_nx = lines_rem_q;
        if (ar_hs) begin
            addr_nx     = addr_q + AXI_ADDR_WIDTH'({burst_len, 3'b000});
            line_rem_nx = line_rem_after;
        end
        if (line_done) begin
            line_rem_nx  = bpl_q;
            lines_rem_nx = lines_rem_q - 12'd1;
        end
        next_len = calc_len(addr_nx[11:0], line_rem_nx);
    end

    // Outstanding-burst counter; a simultaneous issue and termination cancel.
    always_comb begin
        os_cnt_d = os_cnt_q;
        if (ar_hs && !r_dec) begin
            os_cnt_d = os_cnt_q + 1'b1;
        end else if (!ar_hs && r_dec) begin
            os_cnt_d = os_cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        bpl_d         = bpl_q;
        height_d      = height_q;
        line_rem_d    = line_rem_q;
        lines_rem_d   = lines_rem_q;
        arvalid_d     = arvalid_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        line_issued_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dma_trigger_i) begin
                    addr_d   = mem_addr_i;
                    bpl_d    = 12'(({1'b0, image_width_i} + 13'd1) >> 1);
                    height_d = image_height_i;
                    state_d  = S_LOAD;
                end
            end

            S_LOAD: begin
                if ((bpl_q == 12'd0) || (height_q == 12'd0)) begin
                    state_d = S_DONE;
                end else begin
                    line_rem_d  = bpl_q;
                    lines_rem_d = height_q;
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                addr_d        = addr_nx;
                line_rem_d    = line_rem_nx;
                lines_rem_d   = lines_rem_nx;
                line_issued_d = line_done;
                if (frame_issued) begin
                    arvalid_d = 1'b0;
                    state_d   = S_DRAIN;
                end else if (!arvalid_q || ar_hs) begin
                    // A pending request is never withdrawn; a new one is only
                    // offered while the outstanding budget has room.
                    if (os_cnt_d < OS_MAX) begin
                        arvalid_d = 1'b1;
                        araddr_d  = addr_nx;
                        arlen_d   = 8'(next_len - 9'd1);
                    end else begin
                        arvalid_d = 1'b0;
                    end
                end
            end

            S_DRAIN: begin
                if (os_cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (!dma_trigger_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_axi) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            bpl_q         <= '0;
            height_q      <= '0;
            line_rem_q    <= '0;
            lines_rem_q   <= '0;
            os_cnt_q      <= '0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            line_issued_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            bpl_q         <= bpl_d;
            height_q      <= height_d;
            line_rem_q    <= line_rem_d;
            lines_rem_q   <= lines_rem_d;
            os_cnt_q      <= os_cnt_d;
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            line_issued_q <= line_issued_d;
        end
    end

    assign axi.arvalid        = arvalid_q;
    assign axi.araddr         = araddr_q;
    assign axi.arlen          = arlen_q;
    assign dma_trigger_done_o = (state_q == S_DONE);
    assign busy_o             = (state_q != S_IDLE);
    assign line_issued_o      = line_issued_q;

endmodule

// File: tb/tb_dma_rd_burst_ctrl.sv
`timescale 1ns/1ps

module tb_dma_rd_burst_ctrl;
  localparam int AW = 32;
  localparam int MB = 16;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trig = 1'b0;
  logic          done;
  logic          busy;
  logic          line_iss;
  logic [AW-1:0] mem_addr = '0;
  logic [11:0]   width = '0;
  logic [11:0]   height = '0;

  dma_rd_burst_ctrl_if #(.AXI_ADDR_WIDTH(AW)) axi ();

  dma_rd_burst_ctrl #(
    .AXI_ADDR_WIDTH (AW),
    .MAX_BURST_BEATS(MB),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_axi           (clk),
    .rst               (rst),
    .dma_trigger_i     (trig),
    .dma_trigger_done_o(done),
    .mem_addr_i        (mem_addr),
    .image_width_i     (width),
    .image_height_i    (height),
    .axi               (axi),
    .busy_o            (busy),
    .line_issued_o     (line_iss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          len;
    bit          eol;
  } burst_t;

  burst_t exp_q[$];
  int     len_log[$];
  int     model_out = 0;
  int     ar_count  = 0;
  int     exp_total = 0;
  int     checks    = 0;
  int     errors    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void build_frame(input logic [31:0] base, input int w, input int h);
    int          bpl;
    int          rem;
    int          room;
    int          len;
    logic [31:0] a;
    burst_t      b;
    exp_q.delete();
    bpl = (w + 1) / 2;
    a   = base;
    if (bpl == 0 || h == 0) return;
    for (int l = 0; l < h; l++) begin
      rem = bpl;
      while (rem > 0) begin
        room = (4096 - int'(a[11:0])) / 8;
        len  = MB;
        if (rem < len)  len = rem;
        if (room < len) len = room;
        b.addr = a;
        b.len  = len;
        b.eol  = (rem == len);
        exp_q.push_back(b);
        a   = a + 32'(len * 8);
        rem = rem - len;
      end
    end
  endfunction

  task automatic tick(input bit ar_rdy, input bit rl_fire);
    bit          hs;
    bit          rdec;
    bit          pv;
    bit          pulse_exp;
    logic [31:0] pa;
    logic [7:0]  pl;
    burst_t      b;
    axi.arready = ar_rdy;
    if (rl_fire) begin
      axi.rvalid = 1'b1;
      axi.rready = 1'b1;
      axi.rlast  = 1'b1;
    end else begin
      axi.rvalid = 1'($urandom);
      axi.rready = 1'($urandom);
      axi.rlast  = 1'($urandom);
      if (axi.rvalid && axi.rready && axi.rlast) axi.rlast = 1'b0;
    end
    pv        = axi.arvalid;
    pa        = axi.araddr;
    pl        = axi.arlen;
    hs        = pv && ar_rdy;
    pulse_exp = 1'b0;
    if (hs) begin
      chk("ar_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("araddr", pa, b.addr);
        chk("arlen_beats", int'(pl) + 1, b.len);
        pulse_exp = b.eol;
      end
      ar_count++;
      len_log.push_back(int'(pl));
    end
    rdec = rl_fire && (model_out > 0);
    @(posedge clk);
    #1;
    model_out = model_out + (hs ? 1 : 0) - (rdec ? 1 : 0);
    chk("line_issued", line_iss, pulse_exp);
    if (pv && !hs) begin
      chk("ar_hold_valid", axi.arvalid, 1'b1);
      chk("ar_hold_addr", axi.araddr, pa);
      chk("ar_hold_len", axi.arlen, pl);
    end
    if (axi.arvalid) begin
      chk("os_limit", model_out < MO, 1'b1);
      chk("ar_unexpected", exp_q.size() > 0, 1'b1);
    end
    if (done) begin
      chk("done_early", (exp_q.size() == 0) && (model_out == 0), 1'b1);
    end
  endtask

  task automatic do_reset(input int n);
    rst  = 1'b1;
    trig = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_out = 0;
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_line_issued", line_iss, 1'b0);
    chk("rst_arvalid", axi.arvalid, 1'b0);
    chk("rst_araddr", axi.araddr, 32'h0);
    chk("rst_arlen", axi.arlen, 8'h0);
  endtask

  task automatic start_frame(input logic [31:0] base, input int w, input int h);
    mem_addr = base;
    width    = 12'(w);
    height   = 12'(h);
    trig     = 1'b1;
    build_frame(base, w, h);
    exp_total = exp_q.size();
    ar_count  = 0;
    len_log.delete();
    tick(1'b1, 1'b0);
    chk("busy_after_trigger", busy, 1'b1);
    mem_addr = $urandom & 32'hFFFF_FFF8;
    width    = 12'($urandom);
    height   = 12'($urandom);
  endtask

  task automatic finish_frame(input int budget, input bit ar_random);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      tick(ar_random ? ($urandom % 4 != 0) : 1'b1, ($urandom % 3 == 0));
      cyc++;
    end
    chk("done_reached", done, 1'b1);
    chk("all_bursts_issued", ar_count, exp_total);
    trig = 1'b0;
    tick(1'b1, 1'b0);
    chk("done_cleared", done, 1'b0);
    chk("idle_after_done", busy, 1'b0);
  endtask

  task automatic zero_frame(input int w, input int h);
    start_frame(32'h0000_2000, w, h);
    chk("zero_done_wait", done, 1'b0);
    tick(1'b1, 1'b0);
    chk("zero_done_2cyc", done, 1'b1);
    chk("zero_no_ar", axi.arvalid, 1'b0);
    tick(1'b1, 1'b0);
    chk("zero_done_hold", done, 1'b1);
    trig = 1'b0;
    tick(1'b1, 1'b0);
    chk("zero_done_cleared", done, 1'b0);
    chk("zero_ar_count", ar_count, 0);
  endtask

  initial begin
    int cyc;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rready  = 1'b0;
    axi.rlast   = 1'b0;

    do_reset(2);

    start_frame(32'h1000_0000, 64, 2);
    finish_frame(2000, 1'b0);
    chk("A_ar_count", ar_count, 4);
    chk("A_len0", len_log[0], 15);
    chk("A_len3", len_log[3], 15);

    start_frame(32'h0000_0FC0, 40, 1);
    finish_frame(2000, 1'b1);
    chk("B_ar_count", ar_count, 2);
    chk("B_len0", len_log[0], 7);
    chk("B_len1", len_log[1], 11);

    zero_frame(0, 3);
    zero_frame(10, 0);

    start_frame(32'h3000_0000, 512, 1);
    repeat (12) tick(1'b1, 1'b0);
    chk("D_ar_count_cap", ar_count, 4);
    chk("D_arvalid_low", axi.arvalid, 1'b0);
    tick(1'b1, 1'b1);
    repeat (6) tick(1'b1, 1'b0);
    chk("D_ar_count_plus1", ar_count, 5);
    chk("D_arvalid_low2", axi.arvalid, 1'b0);
    finish_frame(3000, 1'b1);

    start_frame(32'h4000_0000, 512, 1);
    cyc = 0;
    while (ar_count < 3 && cyc < 50) begin
      tick(1'b1, 1'b0);
      cyc++;
    end
    chk("E_ar_count3", ar_count, 3);
    repeat (5) tick(1'b0, 1'b0);
    chk("E_arvalid_held", axi.arvalid, 1'b1);
    tick(1'b1, 1'b1);
    repeat (8) tick(1'b1, 1'b0);
    chk("E_ar_count5", ar_count, 5);
    chk("E_arvalid_low", axi.arvalid, 1'b0);
    finish_frame(3000, 1'b1);

    start_frame(32'h5000_0000, 512, 2);
    repeat (3) tick(1'b1, 1'b0);
    do_reset(1);
    tick(1'b1, 1'b0);
    chk("F_idle_after_rst", busy, 1'b0);
    start_frame(32'h6000_0100, 100, 3);
    finish_frame(3000, 1'b1);

    for (int f = 0; f < 5; f++) begin
      logic [31:0] base;
      base = ($urandom & 32'hFFFF_F000) | (32'(4096 - 8 * $urandom_range(1, 40)) & 32'h0000_0FF8);
      start_frame(base, $urandom_range(1, 300), $urandom_range(1, 4));
      finish_frame(4000, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
